// File: rtl/sd_sector_fifo.sv
// sd_sector_fifo: byte FIFO behind sd_controller, framed into SD sectors.
// Optional statistics counters are enabled with SD_SECTOR_FIFO_STATS_EN.
module sd_sector_fifo #(
  parameter int DEPTH        = 1024,
  parameter int SECTOR_BYTES = 512
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     flush_in,
  input  logic                     byte_avail_in,
  input  logic [7:0]               byte_in,
  output logic                     sector_req_out,
  output logic                     sector_done_out,
  output logic [7:0]               data_out,
  output logic                     valid_out,
  input  logic                     ready_in,
  output logic [$clog2(DEPTH):0]   level_out,
`ifdef SD_SECTOR_FIFO_STATS_EN
  output logic [15:0]              sectors_out,
  output logic [15:0]              dropped_out,
`endif
  output logic                     overflow_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(SECTOR_BYTES);

  typedef enum logic {IDLE, FILL} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] byte_cnt;
  logic          avail_q;

  logic          push;
  logic          pop;
  logic          full;
  logic          wr_en;
  logic          drop;
  logic          last;
  logic          room;

  // byte_available is a level; only its rising edge marks a new byte
  assign push  = byte_avail_in & ~avail_q;
  assign valid_out = (level_out != '0);
  assign pop   = valid_out & ready_in;
  assign full  = (level_out == LW'(DEPTH));
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;
  assign last  = push & (byte_cnt == CW'(SECTOR_BYTES - 1));
  assign room  = ((LW'(DEPTH) - level_out) >= LW'(SECTOR_BYTES));

  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (!flush_in && wr_en)
      mem[wr_ptr] <= byte_in;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_out       <= '0;
      byte_cnt        <= '0;
      avail_q         <= 1'b0;
      overflow_out    <= 1'b0;
      sector_req_out  <= 1'b0;
      sector_done_out <= 1'b0;
    end else if (flush_in) begin
      state           <= IDLE;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      level_out       <= '0;
      byte_cnt        <= '0;
      avail_q         <= byte_avail_in;
      overflow_out    <= 1'b0;
      sector_req_out  <= 1'b0;
      sector_done_out <= 1'b0;
    end else begin
      avail_q         <= byte_avail_in;
      sector_done_out <= last;
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !pop)
        level_out <= level_out + 1'b1;
      else if (!wr_en && pop)
        level_out <= level_out - 1'b1;
      if (drop)
        overflow_out <= 1'b1;
      // dropped bytes still count toward the sector framing
      if (push)
        byte_cnt <= byte_cnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (push) begin
            sector_req_out <= 1'b0;
            state          <= last ? IDLE : FILL;
          end else begin
            sector_req_out <= room;
          end
        end
        FILL: begin
          sector_req_out <= 1'b0;
          if (last)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SD_SECTOR_FIFO_STATS_EN
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sectors_out <= '0;
      dropped_out <= '0;
    end else if (flush_in) begin
      sectors_out <= '0;
      dropped_out <= '0;
    end else begin
      if (last && sectors_out != 16'hFFFF)
        sectors_out <= sectors_out + 1'b1;
      if (drop && dropped_out != 16'hFFFF)
        dropped_out <= dropped_out + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sd_sector_fifo.sv
// tb_sd_sector_fifo: directed checks of capture, framing, flow control.
// Stimulus changes 2ns after posedge; all sampling on negedge.
`timescale 1ns/1ps
module tb_sd_sector_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        avail = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        ready = 1'b0;
  logic        sector_req;
  logic        sector_done;
  logic [7:0]  data;
  logic        valid;
  logic [10:0] level;
  logic        overflow;
`ifdef SD_SECTOR_FIFO_STATS_EN
  logic [15:0] sectors;
  logic [15:0] dropped;
`endif

  int total = 0;
  int bad = 0;
  int pops = 0;
  int done_cnt = 0;
  int d0;
  logic [7:0] exp_q[$];

  sd_sector_fifo dut (
    .clk_in          (clk),
    .rst_n_in        (rst_n),
    .flush_in        (flush),
    .byte_avail_in   (avail),
    .byte_in         (byte_in),
    .sector_req_out  (sector_req),
    .sector_done_out (sector_done),
    .data_out        (data),
    .valid_out       (valid),
    .ready_in        (ready),
    .level_out       (level),
`ifdef SD_SECTOR_FIFO_STATS_EN
    .sectors_out     (sectors),
    .dropped_out     (dropped),
`endif
    .overflow_out    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b, input int hi,
                           input int lo, input bit keep);
    byte_in = b;
    avail = 1'b1;
    if (keep) exp_q.push_back(b);
    repeat (hi) tick();
    avail = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic flush_fifo();
    flush = 1'b1;
    exp_q.delete();
    tick();
    flush = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (sector_done) done_cnt++;
      if (valid && ready) begin
        if (exp_q.size() == 0)
          chk("pop_q", exp_q.size(), 1);
        else
          chk("pop_data", data, exp_q.pop_front());
        pops++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset release
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_req0", sector_req, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_done", sector_done, 0);
    @(negedge clk);
    chk("rst_req1", sector_req, 1);
    tick();

    // 2: one sector, streaming consumer
    ready = 1'b1;
    for (int i = 0; i < 512; i++)
      push_byte(i[7:0], 3, 2, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    chk("s2_pops", pops, 512);
    chk("s2_done", done_cnt, 1);
    chk("s2_level", level, 0);
    chk("s2_req", sector_req, 1);
    chk("s2_qempty", exp_q.size(), 0);
    tick();

    // 3: fill past capacity, consumer stalled
    ready = 1'b0;
    flush_fifo();
    d0 = done_cnt;
    byte_in = 8'h00;
    avail = 1'b1;
    exp_q.push_back(8'h00);
    tick();
    @(negedge clk);
    chk("s3_lat_valid", valid, 1);
    chk("s3_lat_data", data, 8'h00);
    chk("s3_lat_level", level, 1);
    chk("s3_fill_req", sector_req, 0);
    avail = 1'b0;
    tick();
    for (int i = 1; i < 1025; i++) begin
      push_byte(i[7:0], 1, 1, i < 1024);
      if (i == 511) begin
        @(negedge clk);
        chk("s3_req_512", sector_req, 1);
        chk("s3_level_512", level, 512);
      end
      if (i == 512) begin
        @(negedge clk);
        chk("s3_req_513", sector_req, 0);
      end
      if (i == 1023) begin
        @(negedge clk);
        chk("s3_ovf_1024", overflow, 0);
        chk("s3_req_full", sector_req, 0);
      end
    end
    @(negedge clk);
    chk("s3_level", level, 1024);
    chk("s3_ovf", overflow, 1);
    chk("s3_req", sector_req, 0);
    chk("s3_head", data, 8'h00);
    chk("s3_valid", valid, 1);
    chk("s3_done", done_cnt - d0, 2);
    tick();

    // 4: push and pop together around the pointer wrap
    ready = 1'b1;
    repeat (1019) tick();
    ready = 1'b0;
    @(negedge clk);
    chk("s4_level5", level, 5);
    chk("s4_head", data, 8'hFB);
    tick();
    for (int k = 0; k < 10; k++) begin
      byte_in = 8'hA0 + k[7:0];
      exp_q.push_back(byte_in);
      avail = 1'b1;
      ready = 1'b1;
      tick();
      avail = 1'b0;
      ready = 1'b0;
      tick();
      @(negedge clk);
      chk("s4_level_pp", level, 5);
    end
    chk("s4_head_wrap", data, 8'hA5);
    tick();
    ready = 1'b1;
    repeat (6) tick();
    ready = 1'b0;
    @(negedge clk);
    chk("s4_drained", level, 0);
    chk("s4_qempty", exp_q.size(), 0);
    tick();

    // 5: flush mid-sector with byte_avail held high
    d0 = done_cnt;
    for (int i = 0; i < 200; i++)
      push_byte(i[7:0], 1, 1, 1'b1);
    @(negedge clk);
    chk("s5_level200", level, 200);
    chk("s5_ovf_pre", overflow, 1);
    tick();
    byte_in = 8'h55;
    avail = 1'b1;
    flush_fifo();
    repeat (3) tick();
    @(negedge clk);
    chk("s5_level", level, 0);
    chk("s5_valid", valid, 0);
    chk("s5_ovf", overflow, 0);
    chk("s5_nodone", done_cnt - d0, 0);
    avail = 1'b0;
    tick();
    ready = 1'b1;
    for (int i = 0; i < 511; i++)
      push_byte(i[7:0], 1, 1, 1'b1);
    @(negedge clk);
    chk("s5_done_early", done_cnt - d0, 0);
    tick();
    byte_in = 8'hFF;
    exp_q.push_back(8'hFF);
    avail = 1'b1;
    tick();
    @(negedge clk);
    chk("s5_pulse_hi", sector_done, 1);
    avail = 1'b0;
    tick();
    @(negedge clk);
    chk("s5_pulse_lo", sector_done, 0);
    tick();
    repeat (3) tick();
    @(negedge clk);
    chk("s5_done", done_cnt - d0, 1);
    chk("s5_qempty", exp_q.size(), 0);
    tick();

`ifdef SD_SECTOR_FIFO_STATS_EN
    // 6: statistics counters
    ready = 1'b0;
    flush_fifo();
    for (int i = 0; i < 1028; i++)
      push_byte(i[7:0], 1, 1, i < 1024);
    ready = 1'b1;
    repeat (1030) tick();
    for (int i = 1028; i < 1536; i++)
      push_byte(i[7:0], 1, 1, 1'b1);
    repeat (4) tick();
    @(negedge clk);
    chk("s6_sectors", sectors, 3);
    chk("s6_dropped", dropped, 4);
    tick();
    ready = 1'b0;
    flush_fifo();
    @(negedge clk);
    chk("s6_sectors_clr", sectors, 0);
    chk("s6_dropped_clr", dropped, 0);
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
